booth_mult_arbiter: RTL and testbench

Shares one signed booth_multiplier between NREQ requesters using round-robin arbitration. Each accepted job is latched and issued to the multiplier as a one-cycle start pulse. The block waits for the multiplier's done, then returns the product to the requester with its ID. It sits between the requesting datapaths and the single multiplier instance.

---
 rtl/booth_mult_arbiter_if.sv | 44 ++++
 rtl/booth_mult_arbiter.sv | 164 ++++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_arbiter_if.sv
// Bundle of requester, response and multiplier-side signals for booth_mult_arbiter.
// resp_err exists only when MUL_TIMEOUT_EN is defined.
interface booth_mult_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [2*W-1:0]    resp_product;
    logic              mul_start;
    logic [W-1:0]      mul_multiplicand;
    logic [W-1:0]      mul_multiplier;
    logic              mul_done;
    logic [2*W-1:0]    mul_product;
    logic              busy;
`ifdef MUL_TIMEOUT_EN
    logic              resp_err;
`endif

    modport master (
        input  req_valid, req_a, req_b, resp_ready, mul_done, mul_product,
        output req_ready, resp_valid, resp_id, resp_product,
        output mul_start, mul_multiplicand, mul_multiplier, busy
`ifdef MUL_TIMEOUT_EN
        , output resp_err
`endif
    );

    modport slave (
        output req_valid, req_a, req_b, resp_ready, mul_done, mul_product,
        input  req_ready, resp_valid, resp_id, resp_product,
        input  mul_start, mul_multiplicand, mul_multiplier, busy
`ifdef MUL_TIMEOUT_EN
        , input resp_err
`endif
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one signed multiplier among NREQ requesters.
// Define MUL_TIMEOUT_EN to add a WAIT watchdog and the resp_err flag.
module booth_mult_arbiter #(
    parameter int NREQ           = 4,
    parameter int W              = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_mult_arbiter_if.master bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BLANK = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         last_q, last_d;
    logic [IDW-1:0]         id_q, id_d;
    logic [W-1:0]           a_q, a_d;
    logic [W-1:0]           b_q, b_d;
    logic [2*W-1:0]         prod_q, prod_d;

    logic [NREQ-1:0][W-1:0] a_arr;
    logic [NREQ-1:0][W-1:0] b_arr;
    logic                   gnt_found;
    logic [IDW-1:0]         gnt_idx;
    logic [IDW-1:0]         cand;
    logic [NREQ-1:0]        gnt_oh;
    logic                   tmo;

    assign a_arr = bus.req_a;
    assign b_arr = bus.req_b;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt_oh = NREQ'(1) << gnt_idx;

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign tmo = (state_q == S_WAIT) && !bus.mul_done &&
                 (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_BLANK) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
            if (bus.mul_done) err_d = 1'b0;
            else if (tmo)     err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.resp_err = err_q;
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // BLANK always takes one cycle so a done left high by the previous job is never seen.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (gnt_found) state_d = S_ISSUE;
            S_ISSUE: state_d = S_BLANK;
            S_BLANK: state_d = S_WAIT;
            S_WAIT:  if (bus.mul_done || tmo) state_d = S_RESP;
            S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.mul_start  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.busy       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                // Gated by rst_n so the accept strobe is also quiet while reset is held.
                if (gnt_found && rst_n) bus.req_ready = gnt_oh;
            end
            S_ISSUE: bus.mul_start  = 1'b1;
            S_RESP:  bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        last_d = last_q;
        id_d   = id_q;
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        if (state_q == S_IDLE && gnt_found) begin
            last_d = gnt_idx;
            id_d   = gnt_idx;
            a_d    = a_arr[gnt_idx];
            b_d    = b_arr[gnt_idx];
        end
        if (state_q == S_WAIT) begin
            if (bus.mul_done) prod_d = bus.mul_product;
            else if (tmo)     prod_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDW'(NREQ - 1);
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
        end else begin
            last_q <= last_d;
            id_q   <= id_d;
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
        end
    end

    assign bus.mul_multiplicand = a_q;
    assign bus.mul_multiplier   = b_q;
    assign bus.resp_id          = id_q;
    assign bus.resp_product     = prod_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a small latency-3 multiplier model
// whose done level stays high until the next job starts.
module tb_booth_mult_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int MLAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mult_arbiter_if #(.NREQ(NREQ), .W(W)) bus();
    booth_mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    int vecs = 0;
    int errs = 0;
    bit hang = 1'b0;
    bit last_err = 1'b0;

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] x, y;
        x = {{4{a[3]}}, a};
        y = {{4{b[3]}}, b};
        return x * y;
    endfunction

    logic       m_start_q, m_busy;
    logic [3:0] m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_start_q       <= 1'b0;
            m_busy          <= 1'b0;
            m_cnt           <= '0;
            bus.mul_done    <= 1'b0;
            bus.mul_product <= '0;
        end else begin
            m_start_q <= bus.mul_start;
            if (m_start_q) begin
                bus.mul_done    <= 1'b0;
                m_busy          <= 1'b1;
                m_cnt           <= 4'(MLAT);
                bus.mul_product <= smul(bus.mul_multiplicand, bus.mul_multiplier);
            end else if (m_busy) begin
                m_cnt <= m_cnt - 4'd1;
                if (m_cnt == 4'd1) begin
                    m_busy       <= 1'b0;
                    bus.mul_done <= !hang;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_job(input logic [3:0] v, output logic [3:0] gnt,
                          output logic [1:0] id, output logic [7:0] prod, output bit to);
        to = 1'b0; gnt = '0; id = '0; prod = '0;
        bus.req_valid = v;
        #1;
        for (int c = 0; c < 40 && bus.req_ready == '0; c++) tick();
        if (bus.req_ready == '0) begin to = 1'b1; return; end
        gnt = bus.req_ready;
        tick();
        for (int c = 0; c < 60 && !bus.resp_valid; c++) tick();
        if (!bus.resp_valid) begin to = 1'b1; return; end
        id   = bus.resp_id;
        prod = bus.resp_product;
`ifdef MUL_TIMEOUT_EN
        last_err = bus.resp_err;
`endif
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        bus.req_valid  = 4'b1111;
        bus.req_a      = 16'h8873;
        bus.req_b      = 16'h787E;
        bus.resp_ready = 1'b0;
        #2;
        vecs++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_product, bus.mul_start,
             bus.mul_multiplicand, bus.mul_multiplier, bus.busy} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d p=%h st=%b a=%h b=%h busy=%b want all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_product, bus.mul_start,
                     bus.mul_multiplicand, bus.mul_multiplier, bus.busy);
        end
        tick(); tick();
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin;
        logic [3:0] gnt; logic [1:0] id; logic [7:0] prod; bit to;
        logic [7:0] exp_p [5] = '{8'hFA, 8'h31, 8'h40, 8'hC8, 8'hFA};
        int         exp_g [5] = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            do_job(4'b1111, gnt, id, prod, to);
            vecs++;
            if (to || gnt !== 4'(1 << exp_g[j])) begin
                errs++; $display("FAIL rr_grant%0d: got %b (timeout=%0d) want %b", j, gnt, to, 4'(1 << exp_g[j]));
            end
            vecs++;
            if (id !== 2'(exp_g[j])) begin
                errs++; $display("FAIL rr_id%0d: got %0d want %0d", j, id, exp_g[j]);
            end
            vecs++;
            if (prod !== exp_p[j]) begin
                errs++; $display("FAIL rr_prod%0d: got %h want %h", j, prod, exp_p[j]);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_single;
        bus.req_valid = 4'b0001;
        #1;
        vecs++;
        if (bus.req_ready !== 4'b0001 || bus.busy !== 1'b0) begin
            errs++; $display("FAIL single_accept: got rdy=%b busy=%b want 0001/0", bus.req_ready, bus.busy);
        end
        tick();
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        #1;
        vecs++;
        if ({bus.mul_start, bus.mul_multiplicand, bus.mul_multiplier, bus.req_ready, bus.busy} !== {1'b1, 4'h3, 4'hE, 4'b0000, 1'b1}) begin
            errs++; $display("FAIL single_issue: got st=%b a=%h b=%h rdy=%b busy=%b want 1/3/e/0000/1",
                             bus.mul_start, bus.mul_multiplicand, bus.mul_multiplier, bus.req_ready, bus.busy);
        end
        tick();
        vecs++;
        if ({bus.mul_start, bus.mul_multiplicand, bus.mul_multiplier} !== {1'b0, 4'h3, 4'hE}) begin
            errs++; $display("FAIL single_blank: got st=%b a=%h b=%h want 0/3/e",
                             bus.mul_start, bus.mul_multiplicand, bus.mul_multiplier);
        end
        for (int c = 0; c < 40 && !bus.resp_valid; c++) tick();
        vecs++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_product !== 8'hFA) begin
            errs++; $display("FAIL single_resp: got v=%b id=%0d p=%h want 1/0/fa",
                             bus.resp_valid, bus.resp_id, bus.resp_product);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        vecs++;
        if (bus.resp_valid !== 1'b0) begin
            errs++; $display("FAIL single_drop: got resp_valid=%b want 0", bus.resp_valid);
        end
        bus.req_a = 16'h8873;
        bus.req_b = 16'h787E;
    endtask

    task automatic test_skip_wrap;
        logic [3:0] gnt; logic [1:0] id; logic [7:0] prod; bit to;
        logic [3:0] vin   [4] = '{4'b0100, 4'b1001, 4'b1001, 4'b0010};
        logic [3:0] exp_g [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [1:0] exp_i [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] exp_p [4] = '{8'h40, 8'hC8, 8'hFA, 8'h31};
        for (int j = 0; j < 4; j++) begin
            do_job(vin[j], gnt, id, prod, to);
            bus.req_valid = '0;
            vecs++;
            if (to || gnt !== exp_g[j]) begin
                errs++; $display("FAIL skip_grant%0d: got %b (timeout=%0d) want %b", j, gnt, to, exp_g[j]);
            end
            vecs++;
            if (id !== exp_i[j] || prod !== exp_p[j]) begin
                errs++; $display("FAIL skip_resp%0d: got id=%0d p=%h want %0d/%h", j, id, prod, exp_i[j], exp_p[j]);
            end
        end
    endtask

    task automatic test_backpressure;
        bus.req_a[3:0] = 4'hF;
        bus.req_b[3:0] = 4'hF;
        bus.req_valid = 4'b0001;
        #1;
        tick();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 40 && !bus.resp_valid; c++) tick();
        for (int c = 0; c < 5; c++) begin
            vecs++;
            if ({bus.resp_valid, bus.resp_id, bus.resp_product, bus.req_ready, bus.busy} !== {1'b1, 2'd0, 8'h01, 4'b0000, 1'b1}) begin
                errs++; $display("FAIL bp_hold%0d: got v=%b id=%0d p=%h rdy=%b busy=%b want 1/0/01/0000/1",
                                 c, bus.resp_valid, bus.resp_id, bus.resp_product, bus.req_ready, bus.busy);
            end
            tick();
        end
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        vecs++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errs++; $display("FAIL bp_release: got v=%b busy=%b want 0/0", bus.resp_valid, bus.busy);
        end
        bus.req_a = 16'h8873;
        bus.req_b = 16'h787E;
    endtask

    task automatic test_reset_mid_job;
        logic [3:0] gnt; logic [1:0] id; logic [7:0] prod; bit to;
        bus.req_valid = 4'b0100;
        #1;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        vecs++;
        if (bus.busy !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mul_multiplicand !== 4'h8) begin
            errs++; $display("FAIL mid_wait: got busy=%b v=%b a=%h want 1/0/8", bus.busy, bus.resp_valid, bus.mul_multiplicand);
        end
        bus.req_valid = 4'b1010;
        #1;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_product, bus.mul_start,
             bus.mul_multiplicand, bus.mul_multiplier, bus.busy} !== '0) begin
            errs++; $display("FAIL mid_reset: got rdy=%b v=%b id=%0d p=%h st=%b a=%h b=%h busy=%b want all 0",
                             bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_product, bus.mul_start,
                             bus.mul_multiplicand, bus.mul_multiplier, bus.busy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        do_job(4'b1010, gnt, id, prod, to);
        bus.req_valid = '0;
        vecs++;
        if (to || gnt !== 4'b0010 || id !== 2'd1) begin
            errs++; $display("FAIL mid_regrant: got gnt=%b id=%0d (timeout=%0d) want 0010/1", gnt, id, to);
        end
        vecs++;
        if (prod !== 8'h31) begin
            errs++; $display("FAIL mid_prod: got %h want 31", prod);
        end
    endtask

`ifdef MUL_TIMEOUT_EN
    task automatic test_timeout;
        logic [3:0] gnt; logic [1:0] id; logic [7:0] prod; bit to;
        int n;
        hang = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        tick();
        bus.req_valid = '0;
        n = 0;
        while (!bus.resp_valid && n < 40) begin
            tick();
            n++;
        end
        vecs++;
        if (n !== 17) begin
            errs++; $display("FAIL tmo_latency: got %0d cycles from start to resp want 17", n);
        end
        vecs++;
        if (bus.resp_err !== 1'b1 || bus.resp_product !== 8'h00 || bus.resp_id !== 2'd0) begin
            errs++; $display("FAIL tmo_resp: got err=%b p=%h id=%0d want 1/00/0", bus.resp_err, bus.resp_product, bus.resp_id);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        hang = 1'b0;
        do_job(4'b0001, gnt, id, prod, to);
        bus.req_valid = '0;
        vecs++;
        if (to || last_err !== 1'b0 || prod !== 8'hFA) begin
            errs++; $display("FAIL tmo_normal: got err=%b p=%h (timeout=%0d) want 0/fa", last_err, prod, to);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_skip_wrap();
        test_backpressure();
        test_reset_mid_job();
`ifdef MUL_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
